// File: rtl/muldiv_unit_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_unit_pkg
// Shared definitions for the RV32M/RV64M multiply-divide unit:
//   - funct3 operation codes (OP_MUL .. OP_REMU)
//   - M-extension funct7 constant. The main decoder uses it to steer
//     instructions to this unit.
//   - FSM state encoding
//   - helpers that say which operands an op treats as signed
// -----------------------------------------------------------------------------
package muldiv_unit_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    // rs1 is signed for MULH, MULHSU, DIV and REM.
    function automatic logic op_signed_a(input logic [2:0] f);
        return (f == OP_MULH) || (f == OP_MULHSU) || (f == OP_DIV) || (f == OP_REM);
    endfunction

    // rs2 is signed for MULH, DIV and REM. MULHSU treats rs2 as unsigned.
    function automatic logic op_signed_b(input logic [2:0] f);
        return (f == OP_MULH) || (f == OP_DIV) || (f == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// -----------------------------------------------------------------------------
// muldiv_unit_div_step
// Performs one combinational restoring-division step on unsigned magnitudes.
// It shifts the next dividend bit into the partial remainder, then subtracts
// the divisor when the divisor fits.
//   rem_i     : current partial remainder (always < divisor_i)
//   bit_i     : next dividend bit, MSB first
//   divisor_i : divisor magnitude
//   rem_o     : next partial remainder
//   q_o       : quotient bit produced by this step
// -----------------------------------------------------------------------------
module muldiv_unit_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic            bit_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_o
);

    logic [XLEN:0] partial;
    logic [XLEN:0] diff;

    assign partial = {rem_i, bit_i};
    assign diff    = partial - {1'b0, divisor_i};

    // rem_i < divisor means partial < 2*divisor. So a non-negative difference
    // always fits in XLEN bits, and the top bit flags a borrow.
    assign q_o   = ~diff[XLEN];
    assign rem_o = q_o ? diff[XLEN-1:0] : partial[XLEN-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M/RV64M multiply/divide unit for the execute stage. It is
// driven by funct3 directly.
// Operation flow:
//   - Operands are converted to magnitudes at accept.
//   - MUL runs XLEN shift-add steps. DIV runs XLEN restoring steps.
//   - FIX applies the sign and selects the result half.
//   - DONE pulses done.
//   - Divide-by-zero and signed overflow finish straight at accept.
// FAST_MUL=1 forms the product combinationally at accept and goes straight
// to FIX.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   start         : M-instruction valid in execute
//   flush         : abort whatever is in flight; beats start
//   funct3        : operation select
//   src_a, src_b  : rs1 / rs2 operands
//   result        : registered result, held until the next op completes
//   done          : one-cycle pulse when result is updated
//   busy          : operation in flight (MUL, DIV, FIX)
//   stall         : hold IF/ID/EX; low in DONE so the pipeline moves on
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int  XLEN     = 32,
    parameter int  FAST_MUL = 0,
    localparam int CNT_W    = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic [XLEN-1:0] result,
    output logic            done,
    output logic            busy,
    output logic            stall
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic             neg_q, neg_d;
    logic [XLEN-1:0]  hi_q, hi_d;      // product high half / partial remainder
    logic [XLEN-1:0]  lo_q, lo_d;      // multiplier -> product low / dividend -> quotient
    logic [XLEN-1:0]  opb_q, opb_d;    // multiplicand / divisor magnitude
    logic [XLEN-1:0]  result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // ---------------- accept-time decode ----------------
    logic            accept;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_by_zero, div_ovf;
    logic [2*XLEN-1:0] fast_prod;

    assign accept = start & ~flush & ((state_q == S_IDLE) | (state_q == S_DONE));

    assign a_neg = op_signed_a(funct3) & src_a[XLEN-1];
    assign b_neg = op_signed_b(funct3) & src_b[XLEN-1];
    assign mag_a = a_neg ? -src_a : src_a;
    assign mag_b = b_neg ? -src_b : src_b;

    assign div_by_zero = funct3[2] & (src_b == '0);
    // Only signed DIV/REM can overflow. These are the ops with funct3[0] == 0.
    assign div_ovf     = funct3[2] & ~funct3[0] & (src_a == MIN_NEG) & (src_b == '1);

    assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};

    // ---------------- iteration datapath ----------------
    logic [XLEN:0]   add_sum;
    logic [XLEN-1:0] div_rem;
    logic            div_q;
    logic            last_step;

    // Shift-add: add the multiplicand into the high half when the current
    // multiplier bit is set. Then shift {carry, hi, lo} right by one.
    assign add_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opb_q : {XLEN{1'b0}})};
    assign last_step = (cnt_q == CNT_W'(XLEN - 1));

    muldiv_unit_div_step #(
        .XLEN(XLEN)
    ) u_div_step (
        .rem_i     (hi_q),
        .bit_i     (lo_q[XLEN-1]),
        .divisor_i (opb_q),
        .rem_o     (div_rem),
        .q_o       (div_q)
    );

    // ---------------- sign fix / result select ----------------
    logic [2*XLEN-1:0] prod_mag, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_val;

    assign prod_mag = {hi_q, lo_q};
    assign prod_fix = neg_q ? -prod_mag : prod_mag;
    assign quo_fix  = neg_q ? -lo_q : lo_q;
    assign rem_fix  = neg_q ? -hi_q : hi_q;

    always_comb begin
        fix_val = prod_fix[XLEN-1:0];
        case (op_q)
            OP_MUL:                     fix_val = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:            fix_val = quo_fix;
            default:                    fix_val = rem_fix;
        endcase
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opb_d    = opb_q;
        result_d = result_q;
        cnt_d    = cnt_q;

        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_d = S_IDLE;
                    if (accept) begin
                        op_d  = funct3;
                        opb_d = mag_b;
                        cnt_d = '0;
                        hi_d  = '0;
                        lo_d  = mag_a;
                        if (div_by_zero) begin
                            result_d = funct3[1] ? src_a : {XLEN{1'b1}};
                            state_d  = S_DONE;
                        end else if (div_ovf) begin
                            result_d = funct3[1] ? {XLEN{1'b0}} : src_a;
                            state_d  = S_DONE;
                        end else if (!funct3[2]) begin
                            neg_d = a_neg ^ b_neg;
                            if (FAST_MUL != 0) begin
                                {hi_d, lo_d} = fast_prod;
                                state_d      = S_FIX;
                            end else begin
                                state_d = S_MUL;
                            end
                        end else begin
                            // Remainder follows the dividend. Quotient is negative
                            // when the signs differ and the divisor is nonzero.
                            neg_d   = funct3[1] ? a_neg : ((a_neg ^ b_neg) & (src_b != '0));
                            state_d = S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    {hi_d, lo_d} = {add_sum, lo_q[XLEN-1:1]};
                    if (last_step) state_d = S_FIX;
                    else           cnt_d   = cnt_q + CNT_W'(1);
                end
                S_DIV: begin
                    hi_d = div_rem;
                    lo_d = {lo_q[XLEN-2:0], div_q};
                    if (last_step) state_d = S_FIX;
                    else           cnt_d   = cnt_q + CNT_W'(1);
                end
                S_FIX: begin
                    result_d = fix_val;
                    state_d  = S_DONE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

    assign result = result_q;
    assign done   = (state_q == S_DONE);
    assign busy   = (state_q == S_MUL) | (state_q == S_DIV) | (state_q == S_FIX);
    assign stall  = accept | busy;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    localparam int XLEN = 32;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        start_f = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic [31:0] result, result_f;
    logic        done, busy, stall;
    logic        done_f, busy_f, stall_f;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(XLEN), .FAST_MUL(0)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .flush(flush),
        .funct3(funct3), .src_a(src_a), .src_b(src_b),
        .result(result), .done(done), .busy(busy), .stall(stall)
    );

    muldiv_unit #(.XLEN(XLEN), .FAST_MUL(1)) dut_f (
        .clk(clk), .reset_n(reset_n), .start(start_f), .flush(flush),
        .funct3(funct3), .src_a(src_a), .src_b(src_b),
        .result(result_f), .done(done_f), .busy(busy_f), .stall(stall_f)
    );

    // ---------------- reference model (plain arithmetic) ----------------
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ub;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ub = {32'b0, b};
        case (f)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MINV && b == 32'hFFFF_FFFF) return a;
                return 32'($signed(a) / $signed(b));
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MINV && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'($signed(a) % $signed(b));
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit fast);
        if (f[2] && (b == 0 || (!f[0] && a == MINV && b == 32'hFFFF_FFFF))) return 1;
        if (!f[2] && fast) return 2;
        return XLEN + 2;
    endfunction

    // Cycle-level expectation for the iterative instance: edges left in flight,
    // last published result, pending result, and whether done is due.
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_res = '0;
    logic [31:0] m_pend = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_res  <= '0;
            m_pend <= '0;
        end else if (flush) begin
            m_left <= 0;
            m_done <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
            if (m_left == 1) m_res <= m_pend;
        end else begin
            m_done <= 1'b0;
            if (start) begin
                if (ref_latency(funct3, src_a, src_b, 0) == 1) begin
                    m_done <= 1'b1;
                    m_res  <= ref_result(funct3, src_a, src_b);
                end else begin
                    m_left <= ref_latency(funct3, src_a, src_b, 0) - 1;
                    m_pend <= ref_result(funct3, src_a, src_b);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of the iterative instance against the model.
    always @(negedge clk) begin
        if (reset_n) begin
            chk("cyc_done", 64'(done), 64'(m_done));
            chk("cyc_busy", 64'(busy), 64'(m_left > 0));
            chk("cyc_stall", 64'(stall), 64'((m_left > 0) || (start && !flush)));
            chk("cyc_result", 64'(result), 64'(m_res));
        end
    end

    // Issue one op, wait for done (bounded), check the result and the latency.
    // When pin=1 the literal expectations are also checked against the model.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat, input bit fast,
                          input bit pin, input string name);
        int   edges;
        logic d;
        if (pin) begin
            chk({name, "_model_res"}, 64'(ref_result(f, a, b)), 64'(exp_res));
            chk({name, "_model_lat"}, 64'(ref_latency(f, a, b, fast)), 64'(exp_lat));
        end
        @(posedge clk); #1;
        funct3 = f; src_a = a; src_b = b;
        if (fast) start_f = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start_f = 1'b0;
        edges = 1;
        d = fast ? done_f : done;
        while (!d && edges < 100) begin
            @(posedge clk); #1;
            edges++;
            d = fast ? done_f : done;
        end
        chk({name, "_done_seen"}, 64'(d), 64'(1));
        chk({name, "_result"}, 64'(fast ? result_f : result), 64'(exp_res));
        chk({name, "_latency"}, 64'(edges), 64'(exp_lat));
        $display("op %s f3=%0d a=%h b=%h -> result=%h edges=%0d", name, f, a, b,
                 fast ? result_f : result, edges);
    endtask

    task automatic flush_after(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int k);
        @(posedge clk); #1;
        funct3 = f; src_a = a; src_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (k) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'(0));
        $display("op flush f3=%0d a=%h b=%h after %0d edges -> result=%h", f, a, b, k + 1, result);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return MINV;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          edges;
        int          seen;
        logic [31:0] prior;
        logic [2:0]  f;
        logic [31:0] a, b;

        // ---- reset ----
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        chk("reset_result", 64'(result), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_stall", 64'(stall), 64'(0));

        // ---- directed vectors ----
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0, 1, "mul");
        run_op(3'd1, MINV, MINV, 32'h4000_0000, 34, 0, 1, "mulh");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0, 1, "mulhu");
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 0, 1, "mulhsu");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0, 1, "div");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0, 1, "rem");
        run_op(3'd5, 32'd100, 32'd7, 32'd14, 34, 0, 1, "divu");
        run_op(3'd7, 32'd100, 32'd7, 32'd2, 34, 0, 1, "remu");
        run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, 1, "divu_by0");
        run_op(3'd4, MINV, 32'hFFFF_FFFF, MINV, 1, 0, 1, "div_ovf");
        run_op(3'd6, MINV, 32'hFFFF_FFFF, 32'd0, 1, 0, 1, "rem_ovf");
        run_op(3'd7, 32'd5, 32'd0, 32'd5, 1, 0, 1, "remu_by0");

        // ---- flush at edge 10 of a DIV ----
        prior = result;
        @(posedge clk); #1;
        funct3 = 3'd5; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
        @(posedge clk); #1;           // edge 1: accepted
        start = 1'b0;
        repeat (8) begin @(posedge clk); #1; end   // edges 2..9
        flush = 1'b1;
        @(posedge clk); #1;           // edge 10
        flush = 1'b0;
        chk("flush10_busy", 64'(busy), 64'(0));
        chk("flush10_result", 64'(result), 64'(prior));
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (done) seen++; end
        chk("flush10_no_done", 64'(seen), 64'(0));
        $display("op flush-div at edge 10 -> result=%h", result);

        // ---- start and flush together: nothing accepted ----
        @(posedge clk); #1;
        funct3 = 3'd0; src_a = 32'd3; src_b = 32'd3; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("startflush_busy", 64'(busy), 64'(0));
        chk("startflush_done", 64'(done), 64'(0));
        $display("op start+flush -> busy=%0b done=%0b", busy, done);

        // ---- back-to-back: second start during DONE ----
        @(posedge clk); #1;
        funct3 = 3'd5; src_a = 32'd1000; src_b = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 1;
        while (!done && edges < 100) begin @(posedge clk); #1; edges++; end
        chk("b2b_first_done", 64'(done), 64'(1));
        chk("b2b_first_result", 64'(result), 64'(111));
        funct3 = 3'd0; src_a = 32'd12; src_b = 32'd11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 1;
        while (!done && edges < 100) begin @(posedge clk); #1; edges++; end
        chk("b2b_gap", 64'(edges), 64'(XLEN + 2));
        chk("b2b_second_result", 64'(result), 64'(132));
        $display("op back-to-back divu/mul -> result=%h gap=%0d", result, edges);

        // ---- fast multiply instance ----
        run_op(3'd0, 32'd3, 32'd4, 32'd12, 2, 1, 1, "fast_mul");
        run_op(3'd1, MINV, MINV, 32'h4000_0000, 2, 1, 1, "fast_mulh");
        run_op(3'd5, 32'd100, 32'd7, 32'd14, 34, 1, 1, "fast_divu");
        for (int i = 0; i < 12; i++) begin
            f = 3'($urandom_range(0, 3)); a = pick(); b = pick();
            run_op(f, a, b, ref_result(f, a, b), ref_latency(f, a, b, 1), 1, 0, "fast_rand");
        end
        chk("fast_idle_busy", 64'(busy_f), 64'(0));
        chk("fast_idle_stall", 64'(stall_f), 64'(0));

        // ---- randomized ops on the iterative instance ----
        for (int i = 0; i < 200; i++) begin
            f = 3'($urandom_range(0, 7)); a = pick(); b = pick();
            if ($urandom_range(0, 9) == 0)
                flush_after(f, a, b, int'($urandom_range(1, 20)));
            else
                run_op(f, a, b, ref_result(f, a, b), ref_latency(f, a, b, 0), 0, 0, "rand");
        end

        // ---- asynchronous reset mid-MUL ----
        @(posedge clk); #1;
        funct3 = 3'd0; src_a = 32'd5; src_b = 32'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("areset_result", 64'(result), 64'(0));
        chk("areset_busy", 64'(busy), 64'(0));
        chk("areset_done", 64'(done), 64'(0));
        $display("op async reset mid-mul -> result=%h busy=%0b", result, busy);
        @(posedge clk); #1 reset_n = 1'b1;
        run_op(3'd0, 32'd5, 32'd6, 32'd30, 34, 0, 1, "post_reset_mul");

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M/RV64M multiply-divide execute unit, parametrised in XLEN, placed beside the ALU in the execute stage.
- Decodes funct3 for the M extension (funct7 = 0000001) directly.
- Runs multi-cycle operations under a start/done handshake.
- Drives a stall to hold the earlier pipeline stages while it is busy.
- Optional single-cycle multiply mode.

Parameters:
XLEN, 32, operand/result width (32 or 64)
FAST_MUL, 0, 1 = combinational multiply (MUL* done in 2 edges); 0 = shift-add iterative
CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
start  in  1  execute-stage M-instruction valid
flush  in  1  pipeline flush; aborts operation
funct3  in  3  M-op select
src_a  in  XLEN  rs1 operand
src_b  in  XLEN  rs2 operand
result  out  XLEN  registered result, held until next accepted op
done  out  1  one-cycle pulse, result valid
busy  out  1  operation in flight
stall  out  1  hold IF/ID/EX

Behaviour:
- Reset (async, reset_n low): state IDLE, result 0, done 0, busy 0, counter 0, internal registers 0.
- Op encoding (funct3): 000 MUL low, 001 MULH s*s high, 010 MULHSU s*u high, 011 MULHU u*u high, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- States:
  - IDLE
  - MUL: XLEN shift-add steps on magnitudes, 2*XLEN product register.
  - DIV: XLEN restoring steps on magnitudes.
  - FIX: sign correction and high/low or quotient/remainder select, written into result.
  - DONE: done = 1 for exactly one cycle, then IDLE.
- Accept: start=1 && flush=0 in IDLE or DONE. Latch funct3, the operand magnitudes and the sign flags. start in MUL/DIV/FIX is ignored.
- Latency in clock edges, start edge to done high:
  - iterative mul/div: XLEN+2
  - FAST_MUL=1 multiply: 2 (IDLE->FIX->DONE)
  - special cases: 1 (IDLE->DONE)
- Special cases, resolved at accept:
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = src_a.
  - Signed overflow (src_a = most negative, src_b = -1): DIV = src_a, REM = 0.
- Sign rules:
  - quotient negative iff signs differ and divisor nonzero.
  - remainder takes the dividend's sign.
  - MULHSU: only src_a is signed.
  - product sign = XOR of the operand signs (MULHSU: src_a sign only).
- busy = 1 in MUL, DIV and FIX.
- stall = (accept condition) OR busy. stall is low in DONE so the pipeline advances and captures result.
- Back-to-back: start during DONE is accepted. done still pulses that cycle and the new op begins.
- flush:
  - In any state, next state is IDLE; done stays 0; result is unchanged.
  - flush with start in the same cycle: flush wins, nothing is accepted.
- Reset mid-operation aborts immediately, with all outputs at reset values.
- Counter: counts 0..XLEN-1 and is cleared on accept. No wrap beyond XLEN-1.
- Width: all internal arithmetic is unsigned on XLEN-bit magnitudes. Negation is two's complement, modulo 2^XLEN.

Decomposition:
- Shared header muldiv_defs.vh:
  - funct3 op localparams: OP_MUL .. OP_REMU
  - state encodings: S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE
  - M-extension funct7 constant 7'b0000001, also used by the main decoder to steer instructions here.
- One sub-module, muldiv_div_step: combinational single restoring-division step (partial remainder, divisor -> next remainder, quotient bit), parametrised by XLEN.

Test Plan (XLEN=32):
- MUL src_a=7, src_b=0xFFFFFFFD -> result 0xFFFFFFEB; done at edge 34; stall high edges 0..33, low in DONE.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0. Each with done at edge 1.
- flush at edge 10 of DIV -> IDLE next edge, no done, result keeps its prior value. start+flush in the same cycle -> not accepted. reset_n low mid-MUL -> result 0, busy 0 asynchronously.
- Back-to-back: second start asserted during DONE -> accepted, two done pulses exactly XLEN+2 edges apart. FAST_MUL=1 MUL 3x4 -> 12 at edge 2.
